// File: rtl/btn_conditioner_if.sv
// Button pad and conditioned-event bundle between the pads/consumers and btn_conditioner.
interface btn_conditioner_if #(
   parameter int unsigned N_BTN = 2
);
   logic [N_BTN-1:0] sys_btn_n;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_long;

   modport master (
      output sys_btn_n,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_long
   );

   modport slave (
      input  sys_btn_n,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_long
   );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronizes active-low pads, debounces them and emits
// single-cycle press/release/long-press events per channel.
module btn_conditioner #(
   parameter int unsigned N_BTN       = 2,
   parameter int unsigned DEB_CYCLES  = 270000,
   parameter int unsigned LONG_CYCLES = 27000000
) (
   input logic              sys_clk,
   input logic              sys_rst_n,
   btn_conditioner_if.slave btn
);
   localparam int unsigned CntMax = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
   localparam int unsigned CW = $clog2(CntMax + 1);
   localparam logic [CW-1:0] DebLast = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] LongMax = CW'(LONG_CYCLES);
   localparam logic [CW-1:0] CntOne  = CW'(1);

   typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

   logic [N_BTN-1:0] level_vec, press_vec, release_vec, long_vec;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic          sync1_q, sync2_q, s;
      state_e        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          level_q, level_d, press_q, press_d;
      logic          release_q, release_d, long_q, long_d;

      // Sync flops reset to the released pad level so a held button is seen as a fresh edge.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            sync1_q   <= btn.sys_btn_n[i];
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
         end
      end

      assign s = ~sync2_q;

      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         long_d    = 1'b0;
         unique case (state_q)
            StIdle: begin
               if (s) begin
                  state_d = StPressWait;
                  cnt_d   = CntOne;
               end
            end
            StPressWait: begin
               if (!s) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (cnt_q >= DebLast) begin
                  state_d = StHeld;
                  level_d = 1'b1;
                  press_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            StHeld: begin
               if (!s) begin
                  state_d = StReleaseWait;
                  cnt_d   = CntOne;
               end else if (cnt_q < LongMax) begin
                  // Saturation at LongMax keeps the long pulse to one per hold.
                  cnt_d  = cnt_q + CntOne;
                  long_d = (cnt_q == LongMax - CntOne);
               end
            end
            StReleaseWait: begin
               if (s) begin
                  state_d = StHeld;
                  cnt_d   = '0;
               end else if (cnt_q >= DebLast) begin
                  state_d   = StIdle;
                  level_d   = 1'b0;
                  release_d = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end

      assign level_vec[i]   = level_q;
      assign press_vec[i]   = press_q;
      assign release_vec[i] = release_q;
      assign long_vec[i]    = long_q;
   end

   assign btn.btn_level   = level_vec;
   assign btn.btn_press   = press_vec;
   assign btn.btn_release = release_vec;
   assign btn.btn_long    = long_vec;
endmodule
